// File: rtl/bram_fifo_ctrl.sv
// Show-ahead FIFO controller wrapping a dual-port BRAM (port A write, port B read).
// Define BRAM_FIFO_FLUSH_EN to add the synchronous flush port.
module bram_fifo_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef BRAM_FIFO_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W+1:0] count,
  output logic              bram_ena,
  output logic              bram_wea,
  output logic [ADDR_W-1:0] bram_addra,
  output logic [DATA_W-1:0] bram_dina,
  output logic              bram_enb,
  output logic              bram_web,
  output logic [ADDR_W-1:0] bram_addrb,
  output logic [DATA_W-1:0] bram_dinb,
  input  logic [DATA_W-1:0] bram_doutb
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W:0]   wr_ptr_r, rd_ptr_r;
  logic [1:0]        held_r;
  logic              inflight_r;
  logic [DATA_W-1:0] skid_r;
  logic [DATA_W-1:0] m_data_r;
  logic              m_valid_r;
  logic              s_ready_r;
  logic [ADDR_W+1:0] count_r;

  logic              flush_s;
  logic              push_s, pop_s, issue_s;
  logic [ADDR_W:0]   stored_s, stored_nx_s;
  logic [2:0]        occ_s;
  logic [1:0]        held_pop_s, held_nx_s;
  logic              inflight_nx_s;
  logic [ADDR_W:0]   wr_ptr_nx_s, rd_ptr_nx_s;
  logic [DATA_W-1:0] head_nx_s, skid_nx_s;
  logic [ADDR_W+1:0] count_nx_s;

`ifdef BRAM_FIFO_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  // Next-state computation for pointers, output buffer and status
  always_comb begin
    stored_s   = wr_ptr_r - rd_ptr_r;
    push_s     = s_valid & s_ready_r & ~flush_s;
    pop_s      = m_valid_r & m_ready & ~flush_s;
    // Slots committed after this edge: held plus returning read, minus the pop.
    occ_s      = 3'(held_r) + 3'(inflight_r) - 3'(pop_s);
    issue_s    = (stored_s != {(ADDR_W + 1){1'b0}}) & (occ_s < 3'd2) & ~flush_s;
    held_pop_s = held_r - 2'(pop_s);

    head_nx_s  = m_data_r;
    skid_nx_s  = skid_r;
    held_nx_s  = held_pop_s;
    if (pop_s && (held_r == 2'd2)) begin
      head_nx_s = skid_r;
    end else begin
      head_nx_s = m_data_r;
    end
    // Returning read data lands in the first slot left free after the pop.
    if (inflight_r) begin
      held_nx_s = held_pop_s + 2'd1;
      case (held_pop_s)
        2'd0:    head_nx_s = bram_doutb;
        2'd1:    skid_nx_s = bram_doutb;
        default: skid_nx_s = skid_r;
      endcase
    end else begin
      held_nx_s = held_pop_s;
    end

    wr_ptr_nx_s   = wr_ptr_r + (ADDR_W + 1)'(push_s);
    rd_ptr_nx_s   = rd_ptr_r + (ADDR_W + 1)'(issue_s);
    inflight_nx_s = issue_s;
    if (flush_s) begin
      wr_ptr_nx_s   = {(ADDR_W + 1){1'b0}};
      rd_ptr_nx_s   = {(ADDR_W + 1){1'b0}};
      held_nx_s     = 2'd0;
      inflight_nx_s = 1'b0;
    end else begin
      inflight_nx_s = issue_s;
    end

    stored_nx_s = wr_ptr_nx_s - rd_ptr_nx_s;
    count_nx_s  = (ADDR_W + 2)'(stored_nx_s) + (ADDR_W + 2)'(held_nx_s)
                + (ADDR_W + 2)'(inflight_nx_s);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= {(ADDR_W + 1){1'b0}};
      rd_ptr_r   <= {(ADDR_W + 1){1'b0}};
      held_r     <= 2'd0;
      inflight_r <= 1'b0;
      skid_r     <= {DATA_W{1'b0}};
      m_data_r   <= {DATA_W{1'b0}};
      m_valid_r  <= 1'b0;
      s_ready_r  <= 1'b0;
      count_r    <= {(ADDR_W + 2){1'b0}};
    end else begin
      wr_ptr_r   <= wr_ptr_nx_s;
      rd_ptr_r   <= rd_ptr_nx_s;
      held_r     <= held_nx_s;
      inflight_r <= inflight_nx_s;
      skid_r     <= skid_nx_s;
      m_data_r   <= head_nx_s;
      m_valid_r  <= (held_nx_s != 2'd0);
      s_ready_r  <= (stored_nx_s < DEPTH_V);
      count_r    <= count_nx_s;
    end
  end

  assign s_ready    = s_ready_r;
  assign m_valid    = m_valid_r;
  assign m_data     = m_data_r;
  assign count      = count_r;

  assign bram_ena   = push_s;
  assign bram_wea   = push_s;
  assign bram_addra = wr_ptr_r[ADDR_W-1:0];
  assign bram_dina  = s_data;
  assign bram_enb   = issue_s;
  assign bram_web   = 1'b0;
  assign bram_addrb = rd_ptr_r[ADDR_W-1:0];
  assign bram_dinb  = {DATA_W{1'b0}};

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Directed bench for bram_fifo_ctrl with a behavioural BRAM and a queue scoreboard.
// Flush checks are compiled in when BRAM_FIFO_FLUSH_EN is defined.
module tb_bram_fifo_ctrl;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_valid, s_ready, m_valid, m_ready;
  logic [DATA_W-1:0] s_data, m_data;
  logic [ADDR_W+1:0] count;
  logic              bram_ena, bram_wea, bram_enb, bram_web;
  logic [ADDR_W-1:0] bram_addra, bram_addrb;
  logic [DATA_W-1:0] bram_dina, bram_dinb, bram_doutb;
`ifdef BRAM_FIFO_FLUSH_EN
  logic              flush;
`endif

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];
  logic [DATA_W-1:0] exp_q [$];
  int                total = 0;
  int                bad = 0;
  int                pop_cnt = 0;
  int                push_cnt = 0;
  logic [DATA_W-1:0] last_pop = 8'h00;

  always #5 clk = ~clk;

  bram_fifo_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef BRAM_FIFO_FLUSH_EN
    .flush(flush),
`endif
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .count(count),
    .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addra(bram_addra), .bram_dina(bram_dina),
    .bram_enb(bram_enb), .bram_web(bram_web), .bram_addrb(bram_addrb), .bram_dinb(bram_dinb),
    .bram_doutb(bram_doutb)
  );

  // Behavioural BRAM: write-first port A, one-cycle registered read on port B
  always @(posedge clk) begin
    if (bram_ena && bram_wea) mem[bram_addra] <= bram_dina;
    if (bram_enb) bram_doutb <= mem[bram_addrb];
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive, sample handshakes mid-cycle, then check count after the edge.
  task automatic cyc(input logic v, input logic [7:0] d, input logic r);
    logic push, pop;
    logic [7:0] e;
    s_valid = v;
    s_data  = d;
    m_ready = r;
    @(negedge clk);
    push = s_valid & s_ready;
    pop  = m_valid & m_ready;
    if (pop) begin
      if (exp_q.size() == 0) begin
        check_val("pop_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check_val("m_data", 32'(m_data), 32'(e));
        last_pop = m_data;
        pop_cnt++;
      end
    end
    if (push) begin
      exp_q.push_back(d);
      push_cnt++;
    end
    @(posedge clk);
    #1;
    check_val("count", 32'(count), 32'(exp_q.size()));
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cyc(1'b0, 8'h00, 1'b1);
      n++;
    end
    check_val("drain_left", 32'(exp_q.size()), 32'd0);
    cyc(1'b0, 8'h00, 1'b1);
    check_val("drain_mvalid", 32'(m_valid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int start;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    m_ready = 1'b0;
`ifdef BRAM_FIFO_FLUSH_EN
    flush   = 1'b0;
`endif
    #12;
    check_val("rst_s_ready", 32'(s_ready), 32'd0);
    check_val("rst_m_valid", 32'(m_valid), 32'd0);
    check_val("rst_count", 32'(count), 32'd0);
    check_val("rst_enb", 32'(bram_enb), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("s_ready_pre_edge", 32'(s_ready), 32'd0);
    @(posedge clk);
    #1;
    check_val("s_ready_rise", 32'(s_ready), 32'd1);
    check_val("count_post_rst", 32'(count), 32'd0);

    // Single word latency
    cyc(1'b1, 8'hA5, 1'b1);
    check_val("single_issue", 32'(bram_enb), 32'd1);
    check_val("single_mv_n1", 32'(m_valid), 32'd0);
    cyc(1'b0, 8'h00, 1'b1);
    check_val("single_mv_n2", 32'(m_valid), 32'd0);
    cyc(1'b0, 8'h00, 1'b1);
    check_val("single_mv", 32'(m_valid), 32'd1);
    check_val("single_data", 32'(m_data), 32'hA5);
    cyc(1'b0, 8'h00, 1'b1);
    check_val("single_done", 32'(m_valid), 32'd0);

    // Fill to full with consumer stalled
    n = 0;
    while (exp_q.size() < 1026 && n < 1500) begin
      cyc(1'b1, 8'(exp_q.size()), 1'b0);
      n++;
    end
    check_val("fill_pushes", 32'(exp_q.size()), 32'd1026);
    check_val("full_s_ready", 32'(s_ready), 32'd0);
    check_val("full_count", 32'(count), 32'd1026);
    cyc(1'b1, 8'hFF, 1'b0);
    check_val("full_blocked", 32'(count), 32'd1026);
    drain(1100);

    // Streaming at full rate
    pop_cnt = 0;
    for (int i = 0; i < 3000; i++) cyc(1'b1, 8'(i), 1'b1);
    check_val("stream_pops", 32'(pop_cnt), 32'd2997);
    check_val("stream_count", 32'(count), 32'd3);
    drain(10);

    // Random backpressure
    start = push_cnt;
    n = 0;
    while ((push_cnt - start) < 4000 && n < 20000) begin
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      n++;
    end
    check_val("rand_pushes", 32'(push_cnt - start), 32'd4000);
    drain(5000);

    // Reset with words queued
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h11 * (i + 1)), 1'b0);
    check_val("pre_rst_data", 32'(m_data), 32'h11);
    s_valid = 1'b1;
    rst_n   = 1'b0;
    #2;
    check_val("mid_rst_s_ready", 32'(s_ready), 32'd0);
    check_val("mid_rst_m_valid", 32'(m_valid), 32'd0);
    check_val("mid_rst_m_data", 32'(m_data), 32'd0);
    check_val("mid_rst_count", 32'(count), 32'd0);
    check_val("mid_rst_ena", 32'(bram_ena), 32'd0);
    check_val("mid_rst_enb", 32'(bram_enb), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n   = 1'b1;
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    check_val("rel_s_ready", 32'(s_ready), 32'd1);
    check_val("rel_count", 32'(count), 32'd0);
    check_val("rel_m_valid", 32'(m_valid), 32'd0);

`ifdef BRAM_FIFO_FLUSH_EN
    // Flush with a read in flight; same-cycle push/pop ignored
    for (int i = 0; i < 300; i++) cyc(1'b1, 8'(i + 1), 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    flush   = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h77;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    flush   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    exp_q.delete();
    check_val("flush_m_valid", 32'(m_valid), 32'd0);
    check_val("flush_count", 32'(count), 32'd0);
    check_val("flush_s_ready", 32'(s_ready), 32'd1);
    cyc(1'b0, 8'h00, 1'b0);
    check_val("flush_discard", 32'(m_valid), 32'd0);
    pop_cnt = 0;
    cyc(1'b1, 8'h3C, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1);
    check_val("flush_pops", 32'(pop_cnt), 32'd1);
    check_val("flush_first", 32'(last_pop), 32'h3C);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
